mem_port_arbiter: RTL and testbench

Shares the CPU's single data-memory read/write port between the instruction-fetch requester and the load/store requester. Arbitrates one access per cycle and prioritises data accesses, with a starvation guard that forces fetch through after a bounded data streak. Tags each read so returning data goes to the correct requester. Kills in-flight fetch responses on a pipeline flush. Sits between the fetch/memory stages and the `mem` block, in place of the separate fetch and data read ports.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_arb_tag_pipe.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// +------------------------------------------------------------------+
// | mem_arb_pkg                                                      |
// | Shared types and defaults for the memory-port arbiter.           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [0:0] {
    DATA_PRI  = 1'b0,
    FETCH_PRI = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DATA  = 2'd2
  } tag_t;

  localparam int C_DEF_AW         = 15;
  localparam int C_DEF_DW         = 16;
  localparam int C_DEF_LATENCY    = 1;
  localparam int C_DEF_MAX_STREAK = 4;

  function automatic tag_t kill_fetch_tag(input tag_t t, input logic kill);
    return (kill && (t == TAG_FETCH)) ? TAG_NONE : t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_tag_pipe.sv
// +------------------------------------------------------------------+
// | mem_arb_tag_pipe                                                 |
// | LATENCY-deep response tag shift register with fetch kill.        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mem_arb_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = C_DEF_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic kill_fetch,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t r_stage [LATENCY];

  // Kill applies to every stage, including the one leaving this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_stage[i] <= TAG_NONE;
      end
    end else begin
      r_stage[0] <= kill_fetch_tag(tag_in, kill_fetch);
      for (int i = 1; i < LATENCY; i++) begin
        r_stage[i] <= kill_fetch_tag(r_stage[i-1], kill_fetch);
      end
    end
  end

  assign tag_out = kill_fetch_tag(r_stage[LATENCY-1], kill_fetch);

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +------------------------------------------------------------------+
// | mem_port_arbiter                                                 |
// | Shares one memory port between fetch and load/store requesters.  |
// | Optional MEM_ARB_STATS_EN adds saturating grant/conflict counts. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = C_DEF_AW,
  parameter int DW         = C_DEF_DW,
  parameter int LATENCY    = C_DEF_LATENCY,
  parameter int MAX_STREAK = C_DEF_MAX_STREAK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          f_req_valid,
  input  logic [AW-1:0] f_req_addr,
  output logic          f_req_ready,
  output logic          f_rsp_valid,
  output logic [DW-1:0] f_rsp_data,
  input  logic          d_req_valid,
  input  logic          d_req_we,
  input  logic [AW-1:0] d_req_addr,
  input  logic [DW-1:0] d_req_wdata,
  output logic          d_req_ready,
  output logic          d_rsp_valid,
  output logic [DW-1:0] d_rsp_data,
  output logic          m_ren,
  output logic [AW-1:0] m_raddr,
  input  logic [DW-1:0] m_rdata,
  output logic          m_wen,
  output logic [AW-1:0] m_waddr,
  output logic [DW-1:0] m_wdata,
  output logic [31:0]   stat_fetch_grants,
  output logic [31:0]   stat_data_grants,
  output logic [31:0]   stat_conflicts
);

  localparam int              C_SW         = $clog2(MAX_STREAK + 1);
  localparam logic [C_SW-1:0] C_STREAK_MAX = C_SW'(MAX_STREAK);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic [C_SW-1:0] r_streak;
  logic [C_SW-1:0] w_streak_nxt;
  logic            w_f_eff;
  logic            w_f_grant;
  logic            w_d_grant;
  logic            w_d_read;
  tag_t            w_tag_in;
  tag_t            w_tag_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= DATA_PRI;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  always_comb begin
    w_f_grant    = 1'b0;
    w_d_grant    = 1'b0;
    w_state_nxt  = r_state;
    w_streak_nxt = r_streak;
    // A flushed fetch is not a competitor, so data may take the slot.
    w_f_eff      = f_req_valid && !flush && !rst;

    if (!rst) begin
      case (r_state)
        FETCH_PRI: begin
          w_f_grant = w_f_eff;
          w_d_grant = d_req_valid && !w_f_eff;
        end
        default: begin
          w_d_grant = d_req_valid;
          w_f_grant = w_f_eff && !d_req_valid;
        end
      endcase
    end

    if (w_f_grant || !f_req_valid) begin
      w_streak_nxt = '0;
    end else if (w_d_grant && (r_streak != C_STREAK_MAX)) begin
      w_streak_nxt = r_streak + 1'b1;
    end

    case (r_state)
      DATA_PRI: begin
        if (w_streak_nxt == C_STREAK_MAX) w_state_nxt = FETCH_PRI;
      end
      FETCH_PRI: begin
        if (w_f_grant || !f_req_valid) w_state_nxt = DATA_PRI;
      end
      default: w_state_nxt = DATA_PRI;
    endcase
  end

  assign f_req_ready = w_f_grant;
  assign d_req_ready = w_d_grant;

  assign w_d_read = w_d_grant && !d_req_we;
  assign m_ren    = w_f_grant || w_d_read;
  assign m_raddr  = w_f_grant ? f_req_addr : (w_d_read ? d_req_addr : '0);
  assign m_wen    = w_d_grant && d_req_we;
  assign m_waddr  = m_wen ? d_req_addr  : '0;
  assign m_wdata  = m_wen ? d_req_wdata : '0;
  assign w_tag_in = w_f_grant ? TAG_FETCH : (w_d_read ? TAG_DATA : TAG_NONE);

  mem_arb_tag_pipe #(
    .LATENCY (LATENCY)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .kill_fetch (flush),
    .tag_in     (w_tag_in),
    .tag_out    (w_tag_out)
  );

  assign f_rsp_valid = !rst && (w_tag_out == TAG_FETCH);
  assign d_rsp_valid = !rst && (w_tag_out == TAG_DATA);
  assign f_rsp_data  = f_rsp_valid ? m_rdata : '0;
  assign d_rsp_data  = d_rsp_valid ? m_rdata : '0;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] r_stat_f;
  logic [31:0] r_stat_d;
  logic [31:0] r_stat_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_f <= '0;
      r_stat_d <= '0;
      r_stat_c <= '0;
    end else begin
      if (w_f_grant && (r_stat_f != '1)) r_stat_f <= r_stat_f + 32'd1;
      if (w_d_grant && (r_stat_d != '1)) r_stat_d <= r_stat_d + 32'd1;
      if (f_req_valid && d_req_valid && (r_stat_c != '1)) r_stat_c <= r_stat_c + 32'd1;
    end
  end

  assign stat_fetch_grants = r_stat_f;
  assign stat_data_grants  = r_stat_d;
  assign stat_conflicts    = r_stat_c;
`else
  assign stat_fetch_grants = '0;
  assign stat_data_grants  = '0;
  assign stat_conflicts    = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +------------------------------------------------------------------+
// | tb_mem_port_arbiter                                              |
// | Self-checking bench: vector table, directed corners, random run. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW  = 15;
  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int MS  = 4;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          f_req_valid;
  logic [AW-1:0] f_req_addr;
  logic          f_req_ready;
  logic          f_rsp_valid;
  logic [DW-1:0] f_rsp_data;
  logic          d_req_valid;
  logic          d_req_we;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata;
  logic          d_req_ready;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic          m_ren;
  logic [AW-1:0] m_raddr;
  logic [DW-1:0] m_rdata;
  logic          m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [31:0]   stat_fetch_grants;
  logic [31:0]   stat_data_grants;
  logic [31:0]   stat_conflicts;

  mem_port_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .LATENCY    (LAT),
    .MAX_STREAK (MS)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flush             (flush),
    .f_req_valid       (f_req_valid),
    .f_req_addr        (f_req_addr),
    .f_req_ready       (f_req_ready),
    .f_rsp_valid       (f_rsp_valid),
    .f_rsp_data        (f_rsp_data),
    .d_req_valid       (d_req_valid),
    .d_req_we          (d_req_we),
    .d_req_addr        (d_req_addr),
    .d_req_wdata       (d_req_wdata),
    .d_req_ready       (d_req_ready),
    .d_rsp_valid       (d_rsp_valid),
    .d_rsp_data        (d_rsp_data),
    .m_ren             (m_ren),
    .m_raddr           (m_raddr),
    .m_rdata           (m_rdata),
    .m_wen             (m_wen),
    .m_waddr           (m_waddr),
    .m_wdata           (m_wdata),
    .stat_fetch_grants (stat_fetch_grants),
    .stat_data_grants  (stat_data_grants),
    .stat_conflicts    (stat_conflicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [14:0] a);
    return {a[7:0], ~a[7:0]} ^ 16'h1357;
  endfunction

  // Memory: 256 words aliased on the low address byte, LAT-cycle read pipe.
  logic [15:0] mem_arr [256];
  logic [15:0] rd_pipe [LAT];

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] <= pat(15'(i));
    for (int i = 0; i < LAT; i++) rd_pipe[i] <= '0;
  end

  always @(posedge clk) begin
    rd_pipe[0] <= mem_arr[m_raddr[7:0]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (m_wen) mem_arr[m_waddr[7:0]] <= m_wdata;
  end

  assign m_rdata = rd_pipe[LAT-1];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: data wins unless fetch has already waited through
  // MS data grants; reads come back LAT cycles later unless flushed.
  typedef struct {
    int          due;
    bit          fetch;
    bit          killed;
    logic [15:0] data;
  } rsp_t;

  rsp_t        pend [$];
  int          waits = 0;
  logic [15:0] ref_mem [256];

  task automatic model_cycle();
    bit          ef, ed, f_eff, efv, edv;
    logic [15:0] edata;
    logic [14:0] era;
    rsp_t        r;
    ef = 0; ed = 0; efv = 0; edv = 0; edata = '0; era = '0;
    if (rst) begin
      pend.delete();
      waits = 0;
    end else begin
      f_eff = f_req_valid && !flush;
      if (waits >= MS) begin
        ef = f_eff;
        ed = d_req_valid && !f_eff;
      end else begin
        ed = d_req_valid;
        ef = f_eff && !d_req_valid;
      end
      if (flush) foreach (pend[i]) if (pend[i].fetch) pend[i].killed = 1'b1;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        r = pend.pop_front();
        if (!r.killed) begin
          efv   = r.fetch;
          edv   = !r.fetch;
          edata = r.data;
        end
      end
    end
    if (ef) era = f_req_addr;
    else if (ed && !d_req_we) era = d_req_addr;

    chk("m_f_ready", f_req_ready, ef);
    chk("m_d_ready", d_req_ready, ed);
    chk("m_ren", m_ren, ef || (ed && !d_req_we));
    chk("m_raddr", m_raddr, era);
    chk("m_wen", m_wen, ed && d_req_we);
    chk("m_waddr", m_waddr, (ed && d_req_we) ? d_req_addr : '0);
    chk("m_wdata", m_wdata, (ed && d_req_we) ? d_req_wdata : '0);
    chk("m_f_rsp_valid", f_rsp_valid, efv);
    chk("m_d_rsp_valid", d_rsp_valid, edv);
    chk("m_f_rsp_data", f_rsp_data, efv ? edata : '0);
    chk("m_d_rsp_data", d_rsp_data, edv ? edata : '0);

    if (!rst) begin
      if (ef) pend.push_back('{cyc + LAT, 1'b1, 1'b0, ref_mem[f_req_addr[7:0]]});
      else if (ed && !d_req_we) pend.push_back('{cyc + LAT, 1'b0, 1'b0, ref_mem[d_req_addr[7:0]]});
      if (ed && d_req_we) ref_mem[d_req_addr[7:0]] = d_req_wdata;
      if (ef || !f_req_valid) waits = 0;
      else if (ed) waits++;
    end
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
    model_cycle();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit fv, input logic [14:0] fa, input bit dv, input bit we,
                       input logic [14:0] da, input logic [15:0] wd, input bit fl);
    f_req_valid = fv;
    f_req_addr  = fa;
    d_req_valid = dv;
    d_req_we    = we;
    d_req_addr  = da;
    d_req_wdata = wd;
    flush       = fl;
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    idle();
    sample();
    advance();
    rst = 1'b0;
  endtask

  typedef struct {
    bit          fv, dv, we, fl;
    bit          ef, ed, eren, ewen;
    logic [14:0] eraddr, ewaddr;
    logic [15:0] ewdata;
  } vec_t;

  vec_t vecs [8];

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(15'(i));

    // fv dv we fl | f d ren wen | raddr waddr wdata  (f=0x111 d=0x222 wd=0x3333)
    vecs[0] = '{0,0,0,0, 0,0,0,0, 15'h000, 15'h000, 16'h0000};
    vecs[1] = '{1,0,0,0, 1,0,1,0, 15'h111, 15'h000, 16'h0000};
    vecs[2] = '{0,1,0,0, 0,1,1,0, 15'h222, 15'h000, 16'h0000};
    vecs[3] = '{0,1,1,0, 0,1,0,1, 15'h000, 15'h222, 16'h3333};
    vecs[4] = '{1,1,0,0, 0,1,1,0, 15'h222, 15'h000, 16'h0000};
    vecs[5] = '{1,0,0,1, 0,0,0,0, 15'h000, 15'h000, 16'h0000};
    vecs[6] = '{1,1,1,1, 0,1,0,1, 15'h000, 15'h222, 16'h3333};
    vecs[7] = '{1,1,1,0, 0,1,0,1, 15'h000, 15'h222, 16'h3333};

    // Reset with both requesters active: everything quiet.
    rst = 1'b1;
    drive(1, 15'h11, 1, 0, 15'h22, 16'h1234, 0);
    for (int k = 0; k < 2; k++) begin
      sample();
      chk("rst_ready", {f_req_ready, d_req_ready}, 0);
      chk("rst_mem_en", {m_ren, m_wen}, 0);
      chk("rst_addr", {m_raddr, m_waddr}, 0);
      chk("rst_wdata", m_wdata, 0);
      chk("rst_rsp", {f_rsp_valid, d_rsp_valid}, 0);
      advance();
    end
    rst = 1'b0;

    foreach (vecs[i]) begin
      reset_cycle();
      drive(vecs[i].fv, 15'h111, vecs[i].dv, vecs[i].we, 15'h222, 16'h3333, vecs[i].fl);
      sample();
      chk("vec_f_ready", f_req_ready, vecs[i].ef);
      chk("vec_d_ready", d_req_ready, vecs[i].ed);
      chk("vec_ren", m_ren, vecs[i].eren);
      chk("vec_wen", m_wen, vecs[i].ewen);
      chk("vec_raddr", m_raddr, vecs[i].eraddr);
      chk("vec_waddr", m_waddr, vecs[i].ewaddr);
      chk("vec_wdata", m_wdata, vecs[i].ewdata);
      advance();
    end

    // Fetch-only stream to 0..3.
    reset_cycle();
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(1, 15'(k), 0, 0, '0, '0, 0);
      else idle();
      sample();
      chk("fs_ready", f_req_ready, 32'(k < 4));
      chk("fs_f_valid", f_rsp_valid, 32'(k >= LAT && k < LAT + 4));
      if (k >= LAT && k < LAT + 4) chk("fs_f_data", f_rsp_data, pat(15'(k - LAT)));
      chk("fs_d_valid", d_rsp_valid, 0);
      advance();
    end

    // Conflict in DATA_PRI: data first, then fetch; responses in order.
    reset_cycle();
    drive(1, 15'h00, 1, 0, 15'h10, '0, 0);
    sample();
    chk("cf_c0_ready", {f_req_ready, d_req_ready}, 2'b01);
    advance();
    drive(1, 15'h00, 0, 0, '0, '0, 0);
    sample();
    chk("cf_c1_f_ready", f_req_ready, 1);
    advance();
    idle();
    sample();
    chk("cf_c2_rsp", {f_rsp_valid, d_rsp_valid}, 2'b01);
    chk("cf_c2_data", d_rsp_data, pat(15'h10));
    advance();
    sample();
    chk("cf_c3_rsp", {f_rsp_valid, d_rsp_valid}, 2'b10);
    chk("cf_c3_data", f_rsp_data, pat(15'h00));
    advance();

    // Starvation guard: D,D,D,D,F,D,D,D,D,F.
    reset_cycle();
    for (int k = 0; k < 10; k++) begin
      drive(1, 15'h40, 1, 0, 15'(8'h30 + k), '0, 0);
      sample();
      chk("streak_f", f_req_ready, 32'(k == 4 || k == 9));
      chk("streak_d", d_req_ready, 32'(k != 4 && k != 9));
      advance();
    end
    idle();
    for (int k = 0; k < 3; k++) begin sample(); advance(); end

    // Flush kills in-flight fetch; load granted with the flush still returns.
    reset_cycle();
    drive(1, 15'h05, 0, 0, '0, '0, 0);
    sample();
    chk("fl_c0_f_ready", f_req_ready, 1);
    advance();
    drive(1, 15'h05, 1, 0, 15'h06, '0, 1);
    sample();
    chk("fl_c1_ready", {f_req_ready, d_req_ready}, 2'b01);
    advance();
    idle();
    sample();
    chk("fl_c2_f_valid", f_rsp_valid, 0);
    advance();
    sample();
    chk("fl_c3_d_valid", d_rsp_valid, 1);
    chk("fl_c3_d_data", d_rsp_data, pat(15'h06));
    chk("fl_c3_f_valid", f_rsp_valid, 0);
    advance();
    drive(1, 15'h07, 0, 0, '0, '0, 0);
    sample();
    advance();
    idle();
    sample();
    advance();
    drive(0, '0, 0, 0, '0, '0, 1);
    sample();
    chk("fl_exit_f_valid", f_rsp_valid, 0);
    advance();
    idle();
    sample();
    chk("fl_after_f_valid", f_rsp_valid, 0);
    advance();

    // Store then load back.
    reset_cycle();
    drive(0, '0, 1, 1, 15'h20, 16'hBEEF, 0);
    sample();
    chk("st_wen", {m_wen, m_ren, d_req_ready}, 3'b101);
    chk("st_waddr", m_waddr, 15'h20);
    chk("st_wdata", m_wdata, 16'hBEEF);
    advance();
    drive(0, '0, 1, 0, 15'h20, '0, 0);
    sample();
    chk("ld_raddr", {m_ren, m_raddr}, {1'b1, 15'h20});
    advance();
    idle();
    sample();
    chk("st_no_rsp", d_rsp_valid, 0);
    advance();
    sample();
    chk("ld_rsp_valid", d_rsp_valid, 1);
    chk("ld_rsp_data", d_rsp_data, 16'hBEEF);
    advance();

    // Reset while in FETCH_PRI with reads in flight.
    reset_cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1, 15'h60, 1, 0, 15'(8'h50 + k), '0, 0);
      sample();
      advance();
    end
    rst = 1'b1;
    sample();
    chk("mr_rst_rsp", {f_rsp_valid, d_rsp_valid}, 0);
    chk("mr_rst_ready", {f_req_ready, d_req_ready}, 0);
    advance();
    rst = 1'b0;
    sample();
    chk("mr_first_ready", {f_req_ready, d_req_ready}, 2'b01);
    chk("mr_c5_rsp", {f_rsp_valid, d_rsp_valid}, 0);
    advance();
    idle();
    sample();
    chk("mr_c6_rsp", {f_rsp_valid, d_rsp_valid}, 0);
    advance();
    for (int k = 0; k < 3; k++) begin sample(); advance(); end

    // Random traffic against the reference model.
    for (int k = 0; k < 1200; k++) begin
      rst = ($urandom_range(99) < 1);
      drive($urandom_range(99) < 60, 15'($urandom_range(63)),
            $urandom_range(99) < 50, $urandom_range(99) < 40,
            15'($urandom_range(63)), 16'($urandom), $urandom_range(99) < 10);
      sample();
      advance();
    end
    rst = 1'b0;
    idle();
    for (int k = 0; k < LAT + 2; k++) begin sample(); advance(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
